// File: rtl/lsu_arb_if.sv
// Requester/LSU bundle for the two-port LSU arbiter.
// Latency: n/a (signal container only).
// Backpressure: requesters hold req/command until gnt; LSU side has no stall.
interface lsu_arb_if;
  logic        i_m0_req;
  logic        i_m0_wren;
  logic [2:0]  i_m0_type;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_wdata;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic [31:0] o_m0_rdata;
  logic        o_m0_err;

  logic        i_m1_req;
  logic        i_m1_wren;
  logic [2:0]  i_m1_type;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_wdata;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_m1_rdata;
  logic        o_m1_err;

  logic [2:0]  o_lsu_type_access;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_lsu_st_data;
  logic        o_lsu_wren;
  logic [31:0] i_lsu_ld_data;
  logic        o_busy;

  // Arbiter view.
  modport slave (
    input  i_m0_req, i_m0_wren, i_m0_type, i_m0_addr, i_m0_wdata,
    output o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_err,
    input  i_m1_req, i_m1_wren, i_m1_type, i_m1_addr, i_m1_wdata,
    output o_m1_gnt, o_m1_rvalid, o_m1_rdata, o_m1_err,
    output o_lsu_type_access, o_lsu_addr, o_lsu_st_data, o_lsu_wren,
    input  i_lsu_ld_data,
    output o_busy
  );

  // Requester/LSU view.
  modport master (
    output i_m0_req, i_m0_wren, i_m0_type, i_m0_addr, i_m0_wdata,
    input  o_m0_gnt, o_m0_rvalid, o_m0_rdata, o_m0_err,
    output i_m1_req, i_m1_wren, i_m1_type, i_m1_addr, i_m1_wdata,
    input  o_m1_gnt, o_m1_rvalid, o_m1_rdata, o_m1_err,
    input  o_lsu_type_access, o_lsu_addr, o_lsu_st_data, o_lsu_wren,
    output i_lsu_ld_data,
    input  o_busy
  );
endinterface

// File: rtl/lsu_arb.sv
// Two-requester arbiter in front of a single-cycle LSU (round-robin or fixed priority).
// Latency: gnt at t, LSU access at t+1, rvalid/rdata at t+2; next gnt at t+3 earliest.
// Backpressure: gnt only in IDLE; requesters hold req and command until gnt.
module lsu_arb #(
  parameter bit P_RR = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_reset,
  lsu_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t      state_q;
  logic        ptr_q;          // index of the requester granted last
  logic        cap_wren_q;
  logic        cap_err_q;
  logic        cap_idx_q;
  logic [2:0]  cap_type_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;
  logic        wren_q;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic        busy_q;

  logic        any_req;
  logic        can_gnt;
  logic        win_d;
  logic        sel_wren_d;
  logic [2:0]  sel_type_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic        sel_err_d;
  logic        rv0;
  logic        rv1;
  logic        ld_ok;

  // Alignment/legality of an access type against the low address bits.
  function automatic logic f_misaligned(input logic [2:0] t, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (t)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = a[0];
      3'b010:         bad = (a != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign any_req = bus.i_m0_req | bus.i_m1_req;
  assign can_gnt = (state_q == IDLE) && !i_reset;

  // Winner selection: lone requester wins; on a tie use pointer (RR) or m0 (fixed).
  always_comb begin
    win_d = 1'b0;
    if (bus.i_m0_req && bus.i_m1_req) begin
      win_d = P_RR ? ~ptr_q : 1'b0;
    end else begin
      win_d = ~bus.i_m0_req;
    end
  end

  // Mux the winning requester's command toward the capture registers.
  always_comb begin
    sel_wren_d  = win_d ? bus.i_m1_wren  : bus.i_m0_wren;
    sel_type_d  = win_d ? bus.i_m1_type  : bus.i_m0_type;
    sel_addr_d  = win_d ? bus.i_m1_addr  : bus.i_m0_addr;
    sel_wdata_d = win_d ? bus.i_m1_wdata : bus.i_m0_wdata;
    sel_err_d   = f_misaligned(sel_type_d, sel_addr_d[1:0]);
  end

  // FSM: capture on grant, drive LSU for one cycle, return completion the cycle after.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      cap_wren_q  <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= 1'b0;
      cap_type_q  <= 3'b000;
      cap_addr_q  <= 32'h0;
      cap_wdata_q <= 32'h0;
      wren_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ISSUE;
            ptr_q       <= win_d;
            cap_wren_q  <= sel_wren_d;
            cap_err_q   <= sel_err_d;
            cap_idx_q   <= win_d;
            cap_type_q  <= sel_type_d;
            cap_addr_q  <= sel_addr_d;
            cap_wdata_q <= sel_wdata_d;
            // A misaligned store never writes the LSU.
            wren_q      <= sel_wren_d & ~sel_err_d;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          state_q   <= DATA;
          wren_q    <= 1'b0;
          rvalid0_q <= ~cap_idx_q;
          rvalid1_q <= cap_idx_q;
        end
        DATA: begin
          state_q   <= IDLE;
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, before the first reset edge too.
  assign rv0   = rvalid0_q & ~i_reset;
  assign rv1   = rvalid1_q & ~i_reset;
  assign ld_ok = ~cap_wren_q & ~cap_err_q;

  assign bus.o_m0_gnt    = can_gnt & any_req & ~win_d;
  assign bus.o_m1_gnt    = can_gnt & any_req & win_d;
  assign bus.o_m0_rvalid = rv0;
  assign bus.o_m1_rvalid = rv1;
  assign bus.o_m0_err    = rv0 & cap_err_q;
  assign bus.o_m1_err    = rv1 & cap_err_q;
  assign bus.o_m0_rdata  = (rv0 && ld_ok) ? bus.i_lsu_ld_data : 32'h0;
  assign bus.o_m1_rdata  = (rv1 && ld_ok) ? bus.i_lsu_ld_data : 32'h0;

  assign bus.o_lsu_type_access = i_reset ? 3'b000 : cap_type_q;
  assign bus.o_lsu_addr        = i_reset ? 32'h0  : cap_addr_q;
  assign bus.o_lsu_st_data     = i_reset ? 32'h0  : cap_wdata_q;
  assign bus.o_lsu_wren        = wren_q & ~i_reset;
  assign bus.o_busy            = busy_q & ~i_reset;

endmodule

// File: tb/tb_lsu_arb.sv
// Bench for lsu_arb: directed scenarios plus random traffic against a cycle-timed reference.
// Latency: reference expects gnt at t, LSU access at t+1, completion at t+2.
// Backpressure: bench requesters hold req/command until they observe gnt.
module tb_lsu_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_arb_if rr_if ();
  lsu_arb_if fp_if ();

  lsu_arb #(.P_RR(1'b1)) u_rr (.i_clk(clk), .i_reset(rst), .bus(rr_if.slave));
  lsu_arb #(.P_RR(1'b0)) u_fp (.i_clk(clk), .i_reset(rst), .bus(fp_if.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fill(input int idx);
    return 32'hC0DE0000 ^ (idx * 32'h00010203);
  endfunction

  // Simple LSU behind the round-robin DUT: write on wren, read data one cycle later.
  bit [31:0] mem_l [256];
  bit        wr_l  [256];
  always @(posedge clk) begin
    if (rr_if.o_lsu_wren) begin
      mem_l[rr_if.o_lsu_addr[9:2]] <= rr_if.o_lsu_st_data;
      wr_l[rr_if.o_lsu_addr[9:2]]  <= 1'b1;
    end
    rr_if.i_lsu_ld_data <= wr_l[rr_if.o_lsu_addr[9:2]] ? mem_l[rr_if.o_lsu_addr[9:2]]
                                                       : fill(int'(rr_if.o_lsu_addr[9:2]));
  end

  // Reference model: a single transaction record timed by its grant cycle.
  bit [31:0]   mem_m [256];
  bit          wr_m  [256];
  bit          m_have;
  int          m_g;
  bit          m_wren, m_err, m_idx, m_last;
  logic [31:0] m_rdata;
  logic [2:0]  e_type;
  logic [31:0] e_addr, e_std;
  bit          g_seen0, g_seen1;
  int          glog_idx[$];
  int          glog_cyc[$];
  int          fp_g0, fp_g1;

  function automatic bit ref_mis(input logic [2:0] t, input logic [31:0] a);
    bit legal;
    legal = (t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    return !legal || (t[1:0] == 2'b01 && a[0]) || (t == 3'b010 && a[1:0] != 2'b00);
  endfunction

  always @(negedge clk) begin : mon
    int          d;
    bit          idle_m, r0, r1, w, eg, ew, eb, erv0, erv1;
    logic [31:0] ca, cd;
    logic [2:0]  ct;
    bit          cw;
    g_seen0 = rr_if.o_m0_gnt;
    g_seen1 = rr_if.o_m1_gnt;
    if (rst) begin
      chk("rst_ctl", {24'h0, rr_if.o_m0_gnt, rr_if.o_m1_gnt, rr_if.o_m0_rvalid, rr_if.o_m1_rvalid,
                      rr_if.o_m0_err, rr_if.o_m1_err, rr_if.o_lsu_wren, rr_if.o_busy}, 32'h0);
      chk("rst_addr", rr_if.o_lsu_addr, 32'h0);
      chk("rst_std", rr_if.o_lsu_st_data, 32'h0);
      chk("rst_rdata", rr_if.o_m0_rdata | rr_if.o_m1_rdata | {29'h0, rr_if.o_lsu_type_access}, 32'h0);
      m_have = 1'b0;
      m_last = 1'b1;
      e_type = 3'b000;
      e_addr = 32'h0;
      e_std  = 32'h0;
    end else begin
      d      = cyc - m_g;
      idle_m = !m_have || d >= 3;
      r0     = rr_if.i_m0_req;
      r1     = rr_if.i_m1_req;
      w      = (r0 && r1) ? !m_last : r1;
      eg     = idle_m && (r0 || r1);
      ew     = m_have && d == 1 && m_wren && !m_err;
      eb     = m_have && (d == 1 || d == 2);
      erv0   = m_have && d == 2 && !m_idx;
      erv1   = m_have && d == 2 && m_idx;
      chk("gnt0", rr_if.o_m0_gnt, eg && !w);
      chk("gnt1", rr_if.o_m1_gnt, eg && w);
      chk("wren", rr_if.o_lsu_wren, ew);
      chk("busy", rr_if.o_busy, eb);
      chk("rvalid0", rr_if.o_m0_rvalid, erv0);
      chk("rvalid1", rr_if.o_m1_rvalid, erv1);
      chk("err0", rr_if.o_m0_err, erv0 && m_err);
      chk("err1", rr_if.o_m1_err, erv1 && m_err);
      chk("rdata0", rr_if.o_m0_rdata, erv0 ? m_rdata : 32'h0);
      chk("rdata1", rr_if.o_m1_rdata, erv1 ? m_rdata : 32'h0);
      chk("lsu_addr", rr_if.o_lsu_addr, e_addr);
      chk("lsu_type", {29'h0, rr_if.o_lsu_type_access}, {29'h0, e_type});
      chk("lsu_std", rr_if.o_lsu_st_data, e_std);
      if (rr_if.o_m0_gnt) begin glog_idx.push_back(0); glog_cyc.push_back(cyc); end
      if (rr_if.o_m1_gnt) begin glog_idx.push_back(1); glog_cyc.push_back(cyc); end
      if (eg) begin
        cw = w ? rr_if.i_m1_wren  : rr_if.i_m0_wren;
        ct = w ? rr_if.i_m1_type  : rr_if.i_m0_type;
        ca = w ? rr_if.i_m1_addr  : rr_if.i_m0_addr;
        cd = w ? rr_if.i_m1_wdata : rr_if.i_m0_wdata;
        m_have  = 1'b1;
        m_g     = cyc;
        m_last  = w;
        m_idx   = w;
        m_wren  = cw;
        m_err   = ref_mis(ct, ca);
        m_rdata = 32'h0;
        e_type  = ct;
        e_addr  = ca;
        e_std   = cd;
        if (!m_err && cw) begin
          mem_m[ca[9:2]] = cd;
          wr_m[ca[9:2]]  = 1'b1;
        end else if (!m_err) begin
          m_rdata = wr_m[ca[9:2]] ? mem_m[ca[9:2]] : fill(int'(ca[9:2]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fp_if.o_m0_gnt) fp_g0++;
      if (fp_if.o_m1_gnt) fp_g1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int k, input bit req, input bit wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d);
    if (k == 0) begin
      rr_if.i_m0_req = req; rr_if.i_m0_wren = wr; rr_if.i_m0_type = t;
      rr_if.i_m0_addr = a;  rr_if.i_m0_wdata = d;
    end else begin
      rr_if.i_m1_req = req; rr_if.i_m1_wren = wr; rr_if.i_m1_type = t;
      rr_if.i_m1_addr = a;  rr_if.i_m1_wdata = d;
    end
  endtask

  task automatic set_req(input int k, input bit req);
    if (k == 0) rr_if.i_m0_req = req;
    else        rr_if.i_m1_req = req;
  endtask

  // Wait (bounded) for requester k's grant; returns its cycle, then drops req.
  task automatic wait_gnt(input int k, output int gc);
    bit got;
    got = 1'b0;
    gc  = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (k == 0 ? rr_if.o_m0_gnt : rr_if.o_m1_gnt) begin
        got = 1'b1;
        gc  = cyc;
      end
    end
    chk("gnt_wait", got, 1);
    step();
    set_req(k, 1'b0);
  endtask

  task automatic run_one(input int k, input bit wr, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d, output int gc);
    step();
    set_cmd(k, 1'b1, wr, t, a, d);
    wait_gnt(k, gc);
  endtask

  initial begin : stim
    int gc0, gc1;
    bit cur, gs;
    set_cmd(0, 0, 0, 3'b000, 32'h0, 32'h0);
    set_cmd(1, 0, 0, 3'b000, 32'h0, 32'h0);
    fp_if.i_m0_req = 0; fp_if.i_m0_wren = 0; fp_if.i_m0_type = 0; fp_if.i_m0_addr = 0; fp_if.i_m0_wdata = 0;
    fp_if.i_m1_req = 0; fp_if.i_m1_wren = 0; fp_if.i_m1_type = 0; fp_if.i_m1_addr = 0; fp_if.i_m1_wdata = 0;
    fp_if.i_lsu_ld_data = 32'h0;
    step();
    step();
    rst = 1'b0;

    // Store word then load it back.
    run_one(0, 1'b1, 3'b010, 32'h4, 32'hABCD1234, gc0);
    @(negedge clk);
    chk("sw_wren", rr_if.o_lsu_wren, 1);
    chk("sw_addr", rr_if.o_lsu_addr, 32'h4);
    chk("sw_data", rr_if.o_lsu_st_data, 32'hABCD1234);
    @(negedge clk);
    chk("sw_rvalid", rr_if.o_m0_rvalid, 1);
    run_one(0, 1'b0, 3'b010, 32'h4, 32'h0, gc0);
    @(negedge clk);
    chk("lw_wren", rr_if.o_lsu_wren, 0);
    @(negedge clk);
    chk("lw_rvalid_t2", rr_if.o_m0_rvalid, 1);
    chk("lw_rdata", rr_if.o_m0_rdata, 32'hABCD1234);

    // Continuous tie on both DUTs straight out of reset.
    step();
    rst = 1'b1;
    set_cmd(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    fp_if.i_m0_req = 1'b1;
    fp_if.i_m1_req = 1'b1;
    step();
    rst = 1'b0;
    glog_idx.delete();
    glog_cyc.delete();
    fp_g0 = 0;
    fp_g1 = 0;
    repeat (12) step();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    fp_if.i_m0_req = 1'b0;
    fp_if.i_m1_req = 1'b0;
    chk("rr_gnt_count", glog_idx.size(), 4);
    for (int i = 0; i < glog_idx.size() && i < 4; i++) begin
      chk("rr_order", glog_idx[i], i % 2);
      if (i > 0) chk("rr_spacing", glog_cyc[i] - glog_cyc[i-1], 3);
    end
    chk("fp_m0_gnts", fp_g0, 4);
    chk("fp_m1_gnts", fp_g1, 0);
    repeat (3) step();
    fp_if.i_m1_req = 1'b1;
    step();
    step();
    fp_if.i_m1_req = 1'b0;
    chk("fp_single_m1", fp_g1, 1);
    step();

    // Misaligned halfword, then a byte store.
    run_one(1, 1'b0, 3'b001, 32'h9, 32'h0, gc1);
    @(negedge clk);
    chk("sh_mis_wren", rr_if.o_lsu_wren, 0);
    @(negedge clk);
    chk("sh_mis_rvalid", rr_if.o_m1_rvalid, 1);
    chk("sh_mis_err", rr_if.o_m1_err, 1);
    chk("sh_mis_rdata", rr_if.o_m1_rdata, 32'h0);
    chk("sh_mis_other", rr_if.o_m0_rvalid, 0);
    run_one(1, 1'b1, 3'b000, 32'h10000000, 32'hEF, gc1);
    @(negedge clk);
    chk("sb_wren", rr_if.o_lsu_wren, 1);
    chk("sb_data", rr_if.o_lsu_st_data, 32'hEF);
    @(negedge clk);

    // Reset during ISSUE aborts; next tie goes to m0.
    run_one(0, 1'b1, 3'b010, 32'h20, 32'h55, gc0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_wren", rr_if.o_lsu_wren, 0);
    chk("abort_rvalid", rr_if.o_m0_rvalid, 0);
    chk("abort_busy", rr_if.o_busy, 0);
    step();
    set_cmd(0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 3'b010, 32'h34, 32'h0);
    @(negedge clk);
    chk("post_rst_tie_m0", rr_if.o_m0_gnt, 1);
    chk("post_rst_tie_m1", rr_if.o_m1_gnt, 0);
    step();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    repeat (3) step();

    // m1 raised during m0's ISSUE is granted exactly three cycles after m0.
    run_one(0, 1'b1, 3'b010, 32'h100, 32'h1234, gc0);
    set_cmd(1, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    wait_gnt(1, gc1);
    chk("late_m1_gnt", gc1, gc0 + 3);
    repeat (3) step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        cur = (k == 0) ? rr_if.i_m0_req : rr_if.i_m1_req;
        gs  = (k == 0) ? g_seen0 : g_seen1;
        if (cur && !gs) begin
          if ($urandom_range(0, 15) == 0) set_req(k, 1'b0);
        end else if ($urandom_range(0, 1) == 0) begin
          set_cmd(k, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF), $urandom);
        end else begin
          set_req(k, 1'b0);
        end
      end
    end
    rst = 1'b0;
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
